ntt_op_scheduler: RTL and testbench
===================================

Name: ntt_op_scheduler

Overview:
- Command scheduler in front of ntt_processor.
- Accepts queued polynomial operations (NTT, INVNTT, MULT, ADDSUB) through a valid/ready command port and buffers them in a small FIFO.
- Issues them one at a time to the core with a one-cycle start pulse, holding mode and offsets stable until the core's last_cycle, then reports completion with a tag.
- Owns the RAM-ownership select so a host port may access the 256x96 coefficient RAM only while the core is idle.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, >= 2.
- TAG_W, 4, width of the user tag returned on completion.
- TO_CYCLES, 1023, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO not full.
- cmd_mode  in  2  0 NTT, 1 INVNTT, 2 MULT, 3 ADDSUB.
- cmd_off_a  in  8  RAM word offset of operand A.
- cmd_off_b  in  8  RAM word offset of operand B (MULT/ADDSUB only).
- cmd_off_w  in  8  RAM word offset for write-back.
- cmd_tag  in  TAG_W  user tag.
- core_start  out  1  one-cycle start pulse to ntt_processor.
- core_mode  out  2  mode to core; held from start until done.
- core_off_a  out  8  r_start_offset_A; held.
- core_off_b  out  8  r_start_offset_B; held.
- core_off_w  out  8  w_data_addr_offset; held.
- core_done  in  1  core last_cycle pulse.
- ram_core_sel  out  1  1 = core drives the RAM, 0 = host.
- cpl_valid  out  1  one-cycle completion pulse.
- cpl_tag  out  TAG_W  tag of the completed command.
- cpl_err  out  1  completion flagged as error (timeout).
- busy  out  1  FIFO non-empty or core running.

Behaviour:
- Reset: all outputs 0; FIFO emptied; FSM to IDLE. Reset mid-operation abandons the command with no completion. The core is reset by the same rst.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full, registered count based.
  - Simultaneous push and pop when full is not allowed: cmd_ready is already 0.
  - Simultaneous push and pop when empty is not bypassed: the command enters the FIFO first.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD, START, WAIT, CPL.
  - IDLE: if FIFO non-empty -> LOAD.
  - LOAD: pop head; latch mode, offsets and tag into the core_* and tag registers; ram_core_sel <= 1 -> START.
  - START: core_start = 1 for exactly this cycle -> WAIT.
  - WAIT: on core_done -> CPL. A core_done outside WAIT is ignored.
  - CPL: cpl_valid = 1 for one cycle; cpl_tag = latched tag; ram_core_sel <= 0. Next state is LOAD if the FIFO is non-empty, else IDLE.
- Latency: from a push into an empty FIFO with the FSM in IDLE, core_start rises 3 cycles later (IDLE, LOAD, START). From core_done, cpl_valid follows 1 cycle later, and the next core_start follows 3 cycles after core_done.
- ram_core_sel: 1 exactly over LOAD..WAIT; it drops in the cycle after CPL is entered. The host must not touch the RAM while it is 1.
- core_* outputs hold their last values when idle; they change only in LOAD.
- cmd_off_b is latched for all modes and is don't-care for NTT/INVNTT.
- Offsets are not range-checked; each operation covers 32 consecutive words, wrapping mod 256 inside the core.
- busy = (count != 0) || (state != IDLE).

Optional Feature:
- Macro NTT_SCHED_TIMEOUT_EN.
- Defined:
  - A counter clears in START and increments each WAIT cycle.
  - If it reaches TO_CYCLES without core_done, the FSM forces CPL with cpl_err = 1.
  - The scheduler then asserts core_start only after one extra idle cycle, so the core returns to idle.
- Undefined: no counter; cpl_err is tied to 0; WAIT waits indefinitely.

Decomposition:
- Package ntt_sched_pkg:
  - Mode encodings MODE_NTT=0, MODE_INVNTT=1, MODE_MULT=2, MODE_ADDSUB=3.
  - FSM state encoding.
  - Command struct {mode, off_a, off_b, off_w, tag}, width 26+TAG_W.
  - RAM constants: 8-bit address, 96-bit word, 12-bit coefficient, 32 words per polynomial.
- One sub-module: ntt_cmd_fifo, a synchronous FIFO of command structs with full/empty/count.

Test Plan:
- Single NTT:
  - Push mode=0, offsets 0/0/0, tag=5 into idle → core_start 3 cycles after the push, ram_core_sel=1.
  - core_done pulsed 100 cycles later → cpl_valid with cpl_tag=5 the next cycle, then ram_core_sel=0 and busy=0.
- Back-to-back:
  - Push 4 commands (tags 1-4, modes 0,1,2,3) in consecutive cycles → cmd_ready stays 1 through 4 pushes and drops on a 5th attempt.
  - Completions arrive in order 1,2,3,4; each core_start is 3 cycles after the previous core_done; core_mode/offsets are stable across each WAIT.
- Stray core_done:
  - Pulse core_done while in IDLE → no cpl_valid, no state change.
- Reset mid-WAIT:
  - Assert rst for 1 cycle during WAIT with 2 commands queued → all outputs 0 the next cycle, FIFO empty, no cpl_valid afterward.
- Offset wrap:
  - MULT with off_a=224, off_b=240, off_w=32 → core_off_* equal 224/240/32 from LOAD+1 until CPL.
- Timeout (NTT_SCHED_TIMEOUT_EN, TO_CYCLES=16):
  - Withhold core_done → cpl_valid with cpl_err=1 exactly 16 WAIT cycles after START; a queued next command then starts normally.

Source files
------------

// File: rtl/ntt_sched_pkg.sv
// Shared definitions for the NTT operation scheduler: mode encodings,
// FSM state encoding, command layout and coefficient-RAM geometry.
package ntt_sched_pkg;

    // Operation modes understood by ntt_processor.
    localparam logic [1:0] MODE_NTT    = 2'd0;
    localparam logic [1:0] MODE_INVNTT = 2'd1;
    localparam logic [1:0] MODE_MULT   = 2'd2;
    localparam logic [1:0] MODE_ADDSUB = 2'd3;

    // Coefficient RAM geometry (256 words x 96 bits, 8 x 12-bit coefficients).
    localparam int RAM_ADDR_W = 8;
    localparam int RAM_WORD_W = 96;
    localparam int COEF_W     = 12;
    localparam int POLY_WORDS = 32;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CPL   = 3'd4
    } sched_state_t;

    // Fixed part of a command. The user tag (TAG_W bits) is appended below
    // this struct in the FIFO word, giving a full command of 26+TAG_W bits:
    // {mode, off_a, off_b, off_w, tag}.
    typedef struct packed {
        logic [1:0]            mode;
        logic [RAM_ADDR_W-1:0] off_a;
        logic [RAM_ADDR_W-1:0] off_b;
        logic [RAM_ADDR_W-1:0] off_w;
    } cmd_base_t;

    localparam int CMD_BASE_W = $bits(cmd_base_t);

endpackage

// File: rtl/ntt_cmd_fifo.sv
// Synchronous command FIFO. Count-based full/empty; pointers wrap
// modulo DEPTH (power of two). Read data is the current head entry.
module ntt_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 30
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ntt_op_scheduler.sv
// Command scheduler in front of ntt_processor. Buffers commands, issues
// them one at a time with a one-cycle start pulse, holds mode/offsets
// stable while the core runs, and reports completion with the user tag.
// Also owns ram_core_sel (1 = core owns the coefficient RAM).
//
// Command handshake: a command transfers on a rising edge where
// cmd_valid && cmd_ready; cmd_ready is !full of the FIFO and does not
// depend on cmd_valid. cmd_* must be stable while cmd_valid is high.
//
// Optional watchdog: define NTT_SCHED_TIMEOUT_EN to force completion with
// cpl_err = 1 when core_done does not arrive within TO_CYCLES WAIT cycles.
module ntt_op_scheduler
    import ntt_sched_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 4,
    parameter int TO_CYCLES = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [7:0]       cmd_off_a,
    input  logic [7:0]       cmd_off_b,
    input  logic [7:0]       cmd_off_w,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             core_start,
    output logic [1:0]       core_mode,
    output logic [7:0]       core_off_a,
    output logic [7:0]       core_off_b,
    output logic [7:0]       core_off_w,
    input  logic             core_done,
    output logic             ram_core_sel,
    output logic             cpl_valid,
    output logic [TAG_W-1:0] cpl_tag,
    output logic             cpl_err,
    output logic             busy
);

    localparam int CMD_W = CMD_BASE_W + TAG_W;

    sched_state_t          state;
    logic [CMD_W-1:0]      fifo_wdata;
    logic [CMD_W-1:0]      fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  fifo_pop;
    cmd_base_t             head_base;
    logic [TAG_W-1:0]      head_tag;

    assign fifo_wdata = {cmd_mode, cmd_off_a, cmd_off_b, cmd_off_w, cmd_tag};
    assign head_base  = cmd_base_t'(fifo_rdata[CMD_W-1 -: CMD_BASE_W]);
    assign head_tag   = fifo_rdata[TAG_W-1:0];
    assign fifo_pop   = (state == ST_LOAD);

    // Held low during reset so every output reads 0 while rst is asserted.
    assign cmd_ready = !fifo_full && !rst;
    assign busy      = (fifo_count != '0) || (state != ST_IDLE);

    ntt_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef NTT_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
`else
    logic unused_to_cycles;
    assign unused_to_cycles = (TO_CYCLES != 0);
    assign cpl_err = 1'b0;
`endif

    // Scheduler FSM with registered outputs; core_* change only in LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            core_start   <= 1'b0;
            core_mode    <= '0;
            core_off_a   <= '0;
            core_off_b   <= '0;
            core_off_w   <= '0;
            ram_core_sel <= 1'b0;
            cpl_valid    <= 1'b0;
            cpl_tag      <= '0;
`ifdef NTT_SCHED_TIMEOUT_EN
            cpl_err      <= 1'b0;
            to_cnt       <= '0;
`endif
        end else begin
            core_start <= 1'b0;
            cpl_valid  <= 1'b0;
`ifdef NTT_SCHED_TIMEOUT_EN
            cpl_err    <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state        <= ST_LOAD;
                        ram_core_sel <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    core_mode  <= head_base.mode;
                    core_off_a <= head_base.off_a;
                    core_off_b <= head_base.off_b;
                    core_off_w <= head_base.off_w;
                    cpl_tag    <= head_tag;
                    core_start <= 1'b1;
                    state      <= ST_START;
                end
                ST_START: begin
`ifdef NTT_SCHED_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_done) begin
                        state        <= ST_CPL;
                        cpl_valid    <= 1'b1;
                        ram_core_sel <= 1'b0;
`ifdef NTT_SCHED_TIMEOUT_EN
                    end else if (to_cnt == TO_W'(TO_CYCLES - 1)) begin
                        state        <= ST_CPL;
                        cpl_valid    <= 1'b1;
                        cpl_err      <= 1'b1;
                        ram_core_sel <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                ST_CPL: begin
                    // After a timeout, pass through IDLE once so the core settles.
`ifdef NTT_SCHED_TIMEOUT_EN
                    if (!fifo_empty && !cpl_err) begin
`else
                    if (!fifo_empty) begin
`endif
                        state        <= ST_LOAD;
                        ram_core_sel <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    ram_core_sel <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_op_scheduler.sv
// Directed scoreboard bench for ntt_op_scheduler. Expected issue and
// completion records are queued as commands are pushed; a negedge
// monitor pops and compares whenever core_start or cpl_valid appears.
module tb_ntt_op_scheduler;

    localparam int DEPTH     = 4;
    localparam int TAG_W     = 4;
    localparam int TO_CYCLES = 16;
`ifdef NTT_SCHED_TIMEOUT_EN
    localparam int DONE_DELAY = 10;
`else
    localparam int DONE_DELAY = 100;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_mode = '0;
    logic [7:0]       cmd_off_a = '0;
    logic [7:0]       cmd_off_b = '0;
    logic [7:0]       cmd_off_w = '0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic             core_start;
    logic [1:0]       core_mode;
    logic [7:0]       core_off_a;
    logic [7:0]       core_off_b;
    logic [7:0]       core_off_w;
    logic             core_done = 1'b0;
    logic             ram_core_sel;
    logic             cpl_valid;
    logic [TAG_W-1:0] cpl_tag;
    logic             cpl_err;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    logic [TAG_W:0] exp_cpl_q[$];
    logic [25:0]    exp_start_q[$];
    logic [25:0]    held_cmd = '0;

    ntt_op_scheduler #(
        .DEPTH     (DEPTH),
        .TAG_W     (TAG_W),
        .TO_CYCLES (TO_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_mode     (cmd_mode),
        .cmd_off_a    (cmd_off_a),
        .cmd_off_b    (cmd_off_b),
        .cmd_off_w    (cmd_off_w),
        .cmd_tag      (cmd_tag),
        .core_start   (core_start),
        .core_mode    (core_mode),
        .core_off_a   (core_off_a),
        .core_off_b   (core_off_b),
        .core_off_w   (core_off_w),
        .core_done    (core_done),
        .ram_core_sel (ram_core_sel),
        .cpl_valid    (cpl_valid),
        .cpl_tag      (cpl_tag),
        .cpl_err      (cpl_err),
        .busy         (busy)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (core_start) begin
                if (exp_start_q.size() == 0) begin
                    check("start_unexpected", 32'(core_start), 32'd0);
                end else begin
                    held_cmd = exp_start_q.pop_front();
                    check("start_cmd", 32'({core_mode, core_off_a, core_off_b, core_off_w}), 32'(held_cmd));
                end
            end
            if (cpl_valid) begin
                if (exp_cpl_q.size() == 0) begin
                    check("cpl_unexpected", 32'(cpl_valid), 32'd0);
                end else begin
                    check("cpl_tag_err", 32'({cpl_err, cpl_tag}), 32'(exp_cpl_q.pop_front()));
                    check("cpl_held_cmd", 32'({core_mode, core_off_a, core_off_b, core_off_w}), 32'(held_cmd));
                end
            end
        end
    end

    // Drive one command for one cycle; call at posedge+1, returns at posedge+1.
    task automatic push_cmd(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] w, input logic [TAG_W-1:0] t, input logic err);
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_off_a = a;
        cmd_off_b = b;
        cmd_off_w = w;
        cmd_tag   = t;
        exp_start_q.push_back({m, a, b, w});
        exp_cpl_q.push_back({err, t});
        @(negedge clk);
        check("cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Count negedges until core_start, bounded.
    task automatic wait_start(input int max_cyc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!core_start && n < max_cyc);
        if (!core_start) check("start_timeout", 32'(core_start), 32'd1);
    endtask

    // Count negedges until cpl_valid, bounded.
    task automatic wait_cpl(input int max_cyc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpl_valid && n < max_cyc);
        if (!cpl_valid) check("cpl_timeout", 32'(cpl_valid), 32'd1);
    endtask

    // core_done high for exactly the next full cycle.
    task automatic pulse_done();
        @(posedge clk);
        #1 core_done = 1'b1;
        @(posedge clk);
        #1 core_done = 1'b0;
    endtask

    initial begin
        int n;
        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ctrl", 32'({core_start, ram_core_sel, cpl_valid, cpl_err, busy, cpl_tag}), 32'd0);
        check("reset_core_bus", 32'({core_mode, core_off_a, core_off_b, core_off_w}), 32'd0);
        check("ready_after_reset", 32'(cmd_ready), 32'd1);

        // Single NTT
        @(posedge clk);
        #1;
        push_cmd(2'd0, 8'd0, 8'd0, 8'd0, 4'd5, 1'b0);
        wait_start(10, n);
        check("single_start_latency", 32'(n), 32'd3);
        check("single_sel_on", 32'(ram_core_sel), 32'd1);
        repeat (DONE_DELAY - 1) @(posedge clk);
        pulse_done();
        @(negedge clk);
        check("single_cpl_valid", 32'(cpl_valid), 32'd1);
        @(negedge clk);
        check("single_idle_sel_busy", 32'({ram_core_sel, busy}), 32'd0);

        // Back-to-back: one running command, then fill the FIFO
        @(posedge clk);
        #1;
        push_cmd(2'd0, 8'd1, 8'd2, 8'd3, 4'd6, 1'b0);
        wait_start(10, n);
        check("b2b_first_latency", 32'(n), 32'd3);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            push_cmd(2'(i), 8'(16 * i), 8'(8 + i), 8'(64 + i), 4'(i + 1), 1'b0);
        end
        cmd_valid = 1'b1;
        cmd_tag   = 4'd15;
        @(negedge clk);
        check("ready_full", 32'(cmd_ready), 32'd0);
        check("busy_full", 32'(busy), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (2 * i) @(posedge clk);
            pulse_done();
            if (i < 4) begin
                wait_start(10, n);
                check("b2b_start_gap", 32'(n), 32'd3);
            end
        end
        @(negedge clk);
        check("b2b_last_cpl", 32'(cpl_valid), 32'd1);
        @(negedge clk);
        check("b2b_idle", 32'({ram_core_sel, busy}), 32'd0);

        // Stray core_done while idle
        pulse_done();
        @(negedge clk);
        check("stray_no_cpl", 32'(cpl_valid), 32'd0);
        @(negedge clk);
        check("stray_idle", 32'({cpl_valid, ram_core_sel, busy}), 32'd0);

        // Reset mid-WAIT with two commands queued
        @(posedge clk);
        #1;
        push_cmd(2'd1, 8'd10, 8'd11, 8'd12, 4'd7, 1'b0);
        wait_start(10, n);
        check("rst_test_latency", 32'(n), 32'd3);
        @(posedge clk);
        #1;
        push_cmd(2'd2, 8'd20, 8'd21, 8'd22, 4'd8, 1'b0);
        push_cmd(2'd3, 8'd30, 8'd31, 8'd32, 4'd9, 1'b0);
        rst = 1'b1;
        exp_start_q.delete();
        exp_cpl_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_ctrl", 32'({core_start, ram_core_sel, cpl_valid, cpl_err, busy, cpl_tag}), 32'd0);
        check("midrst_core_bus", 32'({core_mode, core_off_a, core_off_b, core_off_w}), 32'd0);
        check("midrst_ready", 32'(cmd_ready), 32'd1);
        pulse_done();
        repeat (8) @(negedge clk);
        check("midrst_still_idle", 32'({cpl_valid, ram_core_sel, busy}), 32'd0);

        // Offset wrap on MULT
        @(posedge clk);
        #1;
        push_cmd(2'd2, 8'd224, 8'd240, 8'd32, 4'd10, 1'b0);
        wait_start(10, n);
        check("wrap_latency", 32'(n), 32'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wrap_offsets", 32'({core_mode, core_off_a, core_off_b, core_off_w}),
                  32'({2'd2, 8'd224, 8'd240, 8'd32}));
        end
        pulse_done();
        @(negedge clk);
        check("wrap_cpl", 32'(cpl_valid), 32'd1);

`ifdef NTT_SCHED_TIMEOUT_EN
        // Watchdog: no core_done for the first command
        @(posedge clk);
        #1;
        push_cmd(2'd1, 8'd1, 8'd2, 8'd3, 4'd11, 1'b1);
        push_cmd(2'd0, 8'd4, 8'd5, 8'd6, 4'd12, 1'b0);
        wait_start(10, n);
        check("to_start_latency", 32'(n), 32'd3);
        wait_cpl(40, n);
        check("to_cpl_after_start", 32'(n), 32'd17);
        check("to_cpl_err", 32'(cpl_err), 32'd1);
        wait_start(10, n);
        check("to_next_start_gap", 32'(n), 32'd3);
        pulse_done();
        @(negedge clk);
        check("to_next_cpl", 32'({cpl_valid, cpl_err}), 32'b10);
`endif

        repeat (4) @(negedge clk);
        check("queues_drained", 32'(exp_start_q.size() + exp_cpl_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "bench time limit");
    end

endmodule
